// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch unit.
//   PC_W / INST_W : PC and instruction word widths
//   PC_STEP       : sequential fetch increment (one 32-bit word)
//   state_t       : fetch FSM states (S_REQ, S_WAIT, S_DROP)
//   entry_t       : instruction queue entry {pc, inst}
//   misaligned()  : true when a PC is not word aligned
package ifu_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  function automatic logic misaligned(input logic [PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_inst_queue.sv
// ifu_inst_queue: synchronous FIFO of fetched (pc, inst) pairs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : discard all entries (wins over push and pop)
//   push        : write push_entry; accepted when not full or when popping
//   push_entry  : entry to write
//   pop         : consume the head entry (ignored when empty)
//   head        : current head entry, stable until popped
//   empty, full : occupancy flags
//   count       : number of valid entries (0..DEPTH)
// DEPTH must be a power of two and at least 2.
module ifu_inst_queue
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop,
  output entry_t        head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      slots [DEPTH];

  logic do_pop;
  logic do_push;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || (pop && !empty)) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign head = slots[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage owning the architectural PC.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   cur_pc           : PC of the next word to request (oldPC for next-PC logic)
//   redirect         : one-cycle pulse, taken branch/jump resolved
//   redirect_pc      : redirect target (newPC)
//   imem_req_valid   : fetch request valid
//   imem_req_ready   : memory accepts the request
//   imem_req_addr    : request word address (= cur_pc)
//   imem_rsp_valid   : response word valid, in order, >= 1 cycle after accept
//   imem_rsp_data    : response instruction word
//   inst_valid       : queue head valid toward decode
//   inst_ready       : decode consumes the head
//   inst_pc          : PC of the head instruction
//   inst_data        : head instruction word
//   fetch_misalign   : sticky misaligned-redirect flag
// Build option: IFU_FETCH_ALIGN_CHECK_EN
//   defined   - misaligned redirect sets fetch_misalign and halts fetching
//   undefined - fetch_misalign is 0 and redirect targets are word-aligned
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   cur_pc,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [PC_W-1:0]   inst_pc,
  output logic [INST_W-1:0] inst_data,
  output logic              fetch_misalign
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;

  logic              outstanding;
  logic              credit;
  logic              accept;
  logic              halt;
  logic [PC_W-1:0]   target;

  logic              q_push;
  logic              q_flush;
  entry_t            q_push_entry;
  entry_t            q_head;
  logic              q_empty;
  logic              q_full;
  logic [CNT_W-1:0]  q_count;

  // ---------------------------------------------------------------------------
  // Alignment handling
  // ---------------------------------------------------------------------------
`ifdef IFU_FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (redirect && misaligned(redirect_pc)) begin
      misalign_q <= 1'b1;
    end
  end

  // Target is kept unmodified so the faulting PC is visible on cur_pc.
  assign target         = redirect_pc;
  assign halt           = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  assign target         = redirect_pc & 32'hFFFF_FFFC;
  assign halt           = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request channel
  // ---------------------------------------------------------------------------
  // Any state other than S_REQ has exactly one response in flight.
  assign outstanding = (state_q != S_REQ);

  // occupancy + outstanding < QDEPTH
  assign credit = !q_full &&
                  !(outstanding && (q_count == CNT_W'(QDEPTH - 1)));

  // In S_REQ nothing is pushed, so credit cannot drop while a request waits.
  assign imem_req_valid = rst_n && (state_q == S_REQ) && credit && !halt;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign cur_pc         = pc_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    q_push   = 1'b0;
    q_flush  = 1'b0;

    if (redirect) begin
      // Same-cycle acceptance is cancelled: PC is not advanced and the
      // accepted request becomes the one to drop. A response arriving now is
      // the outstanding one and is discarded in place.
      pc_d    = target;
      q_flush = 1'b1;
      unique case (state_q)
        S_REQ:          state_d = accept ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            q_push  = 1'b1;
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  assign q_push_entry = '{pc: req_pc_q, inst: imem_rsp_data};

  ifu_inst_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (q_flush),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (inst_ready),
    .head       (q_head),
    .empty      (q_empty),
    .full       (q_full),
    .count      (q_count)
  );

  assign inst_valid = !q_empty;
  assign inst_pc    = q_head.pc;
  assign inst_data  = q_head.inst;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized scoreboard bench for ifu_fetch.
// The reference model is the architectural instruction stream: after reset or
// a redirect, decode must see target, target+4, ... in order, each paired
// with the memory word for that address. Expected PCs are queued by the
// driver; a monitor pops one per decode handshake and compares.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int unsigned QD     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cur_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC (RST_PC),
    .QDEPTH   (QD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cur_pc         (cur_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .fetch_misalign (fetch_misalign)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  bit          halted = 1'b0;

  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int unsigned pend_cnt;
  int unsigned n_accept = 0;
  int unsigned n_deliv  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int unsigned act, input int unsigned min);
    n_checks++;
    if (act < min) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  task automatic restart_model(input logic [31:0] t);
    exp_q.delete();
`ifdef IFU_FETCH_ALIGN_CHECK_EN
    exp_next = t;
    if (t[1:0] != 2'b00) halted = 1'b1;
`else
    exp_next = t & 32'hFFFF_FFFC;
`endif
  endtask

  task automatic top_up();
    if (!halted) begin
      while (exp_q.size() < 4) begin
        exp_q.push_back(exp_next);
        exp_next = exp_next + 32'd4;
      end
    end
  endtask

  // One cycle of stimulus, applied just after the falling edge.
  // mem_mode: 0 random ready/latency, 1 always ready + 1-cycle latency,
  //           2 always ready + 2..3-cycle latency.
  // when:     0 no redirect, 1 redirect, 2 redirect iff a request is accepted
  //           this cycle, 3 redirect iff a response arrives this cycle.
  task automatic drive(input int when, input logic [31:0] tgt, input bit dec_rdy,
                       input int mem_mode, output bit fired);
    bit acc;
    bit rspf;
    acc  = 1'b0;
    rspf = 1'b0;
    @(negedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
        rspf           = 1'b1;
      end else begin
        pend_cnt--;
      end
    end
    if (pend)               imem_req_ready = 1'b0;
    else if (mem_mode == 0) imem_req_ready = ($urandom_range(0, 3) != 0);
    else                    imem_req_ready = 1'b1;
    if (!pend && imem_req_valid && imem_req_ready) begin
      acc       = 1'b1;
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt  = (mem_mode == 0) ? $urandom_range(0, 2) :
                  (mem_mode == 1) ? 0 : $urandom_range(1, 2);
      n_accept++;
    end
    case (when)
      1:       fired = 1'b1;
      2:       fired = acc;
      3:       fired = rspf;
      default: fired = 1'b0;
    endcase
    redirect    = fired;
    redirect_pc = tgt;
    inst_ready  = fired ? 1'b0 : dec_rdy;
    if (fired) restart_model(tgt);
    top_up();
  endtask

  // Monitor: compares each decode handshake against the expected stream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
        n_deliv++;
        if (halted) begin
          n_checks++;
          n_fail++;
          $display("FAIL halted_delivery: got pc %h expected no delivery", inst_pc);
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got pc %h expected no delivery", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check32("inst_pc", inst_pc, e);
          check32("inst_data", inst_data, mem_word(e));
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    check32({tag, "_cur_pc"}, cur_pc, RST_PC);
    check32({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check32({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check32({tag, "_misalign"}, {31'd0, fetch_misalign}, 32'd0);
  endtask

  initial begin
    bit          f;
    bit          found;
    int unsigned base;
    logic [31:0] tgt;
    int          r;

    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    restart_model(RST_PC);
    repeat (3) @(negedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;

    // Sequential fetch from reset, fast memory, decode always ready.
    base = n_deliv;
    repeat (20) drive(0, '0, 1'b1, 1, f);
    check_ge("seq_progress", n_deliv - base, 5);

    // Decode stall: exactly QD fetches, then requests stop.
    drive(1, 32'h0000_5000, 1'b0, 1, f);
    base = n_accept;
    repeat (10) drive(0, '0, 1'b0, 1, f);
    check32("stall_accepts", n_accept - base, QD);
    check32("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check32("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
    base = n_deliv;
    repeat (14) drive(0, '0, 1'b1, 1, f);
    check_ge("stall_release", n_deliv - base, 4);

    // Redirect while a response is in flight.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      drive(0, '0, 1'b1, 2, f);
      found = pend && (pend_cnt > 0);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_inflight: got timeout expected accepted request");
    end
    drive(1, 32'h0000_4000, 1'b0, 2, f);
    drive(0, '0, 1'b1, 2, f);
    check32("wait_redir_flush", {31'd0, inst_valid}, 32'd0);
    check32("wait_redir_pc", cur_pc, 32'h0000_4000);
    base = n_deliv;
    repeat (16) drive(0, '0, 1'b1, 1, f);
    check_ge("wait_redir_progress", n_deliv - base, 3);

    // Redirect in the same cycle as request acceptance.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      drive(2, 32'h0000_6000, 1'b1, 1, f);
      found = f;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_accept: got timeout expected accepted request");
    end
    drive(0, '0, 1'b0, 1, f);
    check32("acc_redir_pc", cur_pc, 32'h0000_6000);
    check32("acc_redir_empty", {31'd0, inst_valid}, 32'd0);
    repeat (12) drive(0, '0, 1'b1, 1, f);

    // Redirect in the same cycle as a response (would-be queue push).
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      drive(3, 32'h0000_7000, 1'b1, 0, f);
      found = f;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_rsp: got timeout expected response");
    end
    drive(0, '0, 1'b0, 1, f);
    check32("rsp_redir_pc", cur_pc, 32'h0000_7000);
    check32("rsp_redir_empty", {31'd0, inst_valid}, 32'd0);
    repeat (12) drive(0, '0, 1'b1, 1, f);

    // Address wrap at the top of the address space.
    drive(1, 32'hFFFF_FFFC, 1'b0, 1, f);
    base = n_deliv;
    repeat (12) drive(0, '0, 1'b1, 1, f);
    check_ge("wrap_progress", n_deliv - base, 3);

    // Reset while a response is outstanding; the late response must be ignored.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      drive(0, '0, 1'b1, 2, f);
      found = pend && (pend_cnt > 0);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_inflight2: got timeout expected accepted request");
    end
    @(negedge clk);
    #1;
    rst_n          = 1'b0;
    redirect       = 1'b0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    restart_model(RST_PC);
    @(negedge clk);
    #1;
    reset_checks("midrst");
    rst_n = 1'b1;
    base = n_deliv;
    repeat (16) drive(0, '0, 1'b1, 0, f);
    check_ge("midrst_progress", n_deliv - base, 1);

    // Randomized traffic with redirects of all flavours.
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 29);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      drive((r < 3) ? r + 1 : 0, tgt, ($urandom_range(0, 3) != 0), 0, f);
    end
    base = n_deliv;
    repeat (20) drive(0, '0, 1'b1, 1, f);
    check_ge("rand_drain", n_deliv - base, 4);

    // Misaligned redirect target.
    drive(1, 32'h0000_3002, 1'b0, 1, f);
    repeat (3) drive(0, '0, 1'b1, 1, f);
    base = n_accept;
    repeat (8) drive(0, '0, 1'b1, 1, f);
`ifdef IFU_FETCH_ALIGN_CHECK_EN
    check32("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    check32("mis_accepts", n_accept - base, 32'd0);
    check32("mis_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check32("mis_cur_pc", cur_pc, 32'h0000_3002);
`else
    check32("mis_flag", {31'd0, fetch_misalign}, 32'd0);
    check_ge("mis_accepts", n_accept - base, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage that owns the architectural PC register.
- Exports the current PC to the next-PC logic and accepts its computed target on redirect.
- Issues word fetches to instruction memory over a valid/ready request plus valid-only response channel.
- Buffers returned words in a small queue and presents (pc, instruction) pairs to decode with valid/ready.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- QDEPTH, 2, instruction queue depth; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cur_pc  output  32  PC of the next word to request; this is oldPC for next-PC logic.
- redirect  input  1  one-cycle pulse; a resolved taken branch or jump.
- redirect_pc  input  32  target PC (newPC), sampled when redirect=1.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word address equal to cur_pc.
- imem_rsp_valid  input  1  response word valid; arrives at least 1 cycle after acceptance, in order.
- imem_rsp_data  input  32  instruction word.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode consumes head.
- inst_pc  output  32  PC of head instruction.
- inst_data  output  32  head instruction word.
- fetch_misalign  output  1  sticky misaligned-target flag; see Optional Feature.

Behaviour:
- Reset (async assert, sync deassert use): cur_pc=RESET_PC, state=S_REQ, queue empty, inst_valid=0, imem_req_valid=0 during reset, fetch_misalign=0, outstanding=0.
- One outstanding request maximum.
- Credit rule: request only when queue occupancy + outstanding < QDEPTH.
- States:
  - S_REQ: imem_req_valid=credit available. On req accepted: latch req_pc=cur_pc, cur_pc<=cur_pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), go S_WAIT.
  - S_WAIT: on imem_rsp_valid: push {req_pc, data} to queue, go S_REQ.
  - S_DROP: wait for the outstanding response, discard it (no push), go S_REQ.
- Redirect (any state, highest priority):
  - cur_pc<=redirect_pc; queue flushed (occupancy=0, inst_valid=0 next cycle).
  - Same-cycle request acceptance is cancelled: cur_pc is not incremented and the request is treated as outstanding-to-drop.
  - From S_WAIT, or S_REQ with same-cycle acceptance, go S_DROP. Otherwise go S_REQ.
  - A response arriving in the same cycle as a redirect is discarded; if it was the outstanding one, go S_REQ.
  - Redirect in S_DROP: update cur_pc, remain S_DROP.
- Queue:
  - Simultaneous push and pop allowed when full (pop frees the slot first).
  - Push into empty queue makes inst_valid=1 the next cycle; no combinational bypass, so fetch-to-decode latency is 1 cycle after rsp_valid.
  - inst_pc/inst_data stable while inst_valid=1 and inst_ready=0.
- imem_req_addr/imem_req_valid stable until accepted unless redirect.
- Reset mid-transaction: all state cleared; a late response after reset is ignored (state S_REQ, no outstanding).

Optional Feature:
- Macro: IFU_FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 (sticky until reset), flushes the queue, and halts requests (imem_req_valid held 0).
  - cur_pc still loads the target for exception reporting.
- Undefined: fetch_misalign tied 0; the low two bits of redirect_pc are forced to 00 when loaded.

Decomposition:
- Package ifu_pkg:
  - state enum S_REQ/S_WAIT/S_DROP.
  - PC_W=32 and INST_W=32.
  - PC_STEP=4.
  - Queue entry struct {pc, inst}.
- One natural sub-module: ifu_inst_queue (parameterised synchronous FIFO with flush, push, pop, occupancy). Owns full/empty and wrap of read/write pointers.

Test Plan:
- Reset, memory always ready, 1-cycle response latency, decode always ready -> inst_pc sequence 0x3000, 0x3004, 0x3008, and so on, with data matching.
- Decode stalls (inst_ready=0) for 10 cycles -> exactly QDEPTH=2 entries fetched, then imem_req_valid=0; release -> no loss, no duplicate.
- Redirect to 0x0000_4000 while in S_WAIT -> the in-flight response is dropped; next inst_pc=0x4000; no stale 0x300C delivered.
- Redirect in the same cycle as request acceptance and as a queue push -> the queue ends empty, cur_pc=target, and only target-stream words are delivered.
- Redirect to 0xFFFF_FFFC -> inst_pc FFFF_FFFC, then 0000_0000 (wrap).
- With IFU_FETCH_ALIGN_CHECK_EN defined, redirect to 0x3002 -> fetch_misalign=1, no further requests. Without the macro, the same stimulus fetches from 0x3000.
